// File: rtl/sd_buf_pkg.sv
// Shared constants and write-FSM encoding for the ping-pong SD sector buffer.
package sd_buf_pkg;

   localparam int SECTOR_BYTES = 512;
   localparam int BANK_W       = 1;
   localparam int PTR_W        = 9;

   typedef logic [1:0] wr_state_t;

   localparam wr_state_t WR_WAIT = 2'd0;
   localparam wr_state_t WR_FILL = 2'd1;
   localparam wr_state_t WR_DROP = 2'd2;

endpackage

// File: rtl/sd_sector_buffer_ctrl.sv
// Ping-pong arbiter for a 1024x8 single-port BRAM: the SPI writer fills one
// 512-byte bank while the host drains the other; writes always win the port.
module sd_sector_buffer_ctrl
   import sd_buf_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 8,
   parameter int SECTOR_BYTES = sd_buf_pkg::SECTOR_BYTES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   input  logic              wr_sof,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_req,
   output logic              rd_gnt,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              sector_ready,
   output logic              wr_overflow,
   output logic              wr_abort,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              bram_wr_en,
   output logic [DATA_W-1:0] bram_data_in,
   input  logic [DATA_W-1:0] bram_data_out
);

   localparam int              PW       = ADDR_W - 1;
   localparam logic [PW-1:0]   PTR_LAST = PW'(SECTOR_BYTES - 1);

   wr_state_t       state, state_n;
   logic [1:0]      full, full_n, full_set, full_clr;
   logic            wr_bank, wr_bank_n, rd_bank;
   logic [PW-1:0]   wr_ptr, wr_ptr_n, wr_addr_ptr, rd_ptr, drop_cnt, drop_n;
   logic            wr_acc, ovf_set, abort_set;

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_n     = state;
      wr_bank_n   = wr_bank;
      wr_ptr_n    = wr_ptr;
      wr_addr_ptr = wr_ptr;
      drop_n      = drop_cnt;
      full_set    = '0;
      ovf_set     = 1'b0;
      abort_set   = 1'b0;
      wr_acc      = 1'b0;
      if (wr_valid) begin
         case (state)
            WR_FILL: begin
               wr_acc = 1'b1;
               if (wr_sof) begin
                  abort_set   = 1'b1;
                  wr_addr_ptr = '0;
                  wr_ptr_n    = PW'(1);
               end else if (wr_ptr == PTR_LAST) begin
                  full_set[wr_bank] = 1'b1;
                  wr_bank_n         = ~wr_bank;
                  wr_ptr_n          = '0;
                  state_n           = WR_WAIT;
               end else begin
                  wr_ptr_n = wr_ptr + PW'(1);
               end
            end
            default: begin
               // A fresh sof in WR_DROP is handled exactly like one in WR_WAIT.
               if (wr_sof) begin
                  if (full[wr_bank]) begin
                     ovf_set = 1'b1;
                     drop_n  = PW'(1);
                     state_n = WR_DROP;
                  end else begin
                     wr_acc      = 1'b1;
                     wr_addr_ptr = '0;
                     wr_ptr_n    = PW'(1);
                     state_n     = WR_FILL;
                  end
               end else if (state == WR_DROP) begin
                  if (drop_cnt == PTR_LAST) begin
                     drop_n  = '0;
                     state_n = WR_WAIT;
                  end else begin
                     drop_n = drop_cnt + PW'(1);
                  end
               end
            end
         endcase
      end
   end

   assign rd_gnt       = rd_req & full[rd_bank] & ~wr_acc;
   assign bram_wr_en   = wr_acc;
   assign bram_data_in = wr_data;
   assign bram_addr    = wr_acc ? {wr_bank, wr_addr_ptr} : {rd_bank, rd_ptr};
   assign rd_data      = bram_data_out;

   always_comb begin
      full_clr = '0;
      full_clr[rd_bank] = rd_gnt & (rd_ptr == PTR_LAST);
   end

   // Writer and reader never touch the same bank's flag in one cycle.
   assign full_n = (full & ~full_clr) | full_set;

   // NOTE: sequential state uses non-blocking assignments only; BRAM contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= WR_WAIT;
         full         <= '0;
         wr_bank      <= 1'b0;
         rd_bank      <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         drop_cnt     <= '0;
         rd_valid     <= 1'b0;
         rd_last      <= 1'b0;
         sector_ready <= 1'b0;
         wr_overflow  <= 1'b0;
         wr_abort     <= 1'b0;
      end else begin
         state        <= state_n;
         full         <= full_n;
         wr_bank      <= wr_bank_n;
         wr_ptr       <= wr_ptr_n;
         drop_cnt     <= drop_n;
         rd_valid     <= rd_gnt;
         rd_last      <= rd_gnt & (rd_ptr == PTR_LAST);
         sector_ready <= |full_n;
         if (ovf_set)   wr_overflow <= 1'b1;
         if (abort_set) wr_abort    <= 1'b1;
         if (rd_gnt) begin
            if (rd_ptr == PTR_LAST) begin
               rd_ptr  <= '0;
               rd_bank <= ~rd_bank;
            end else begin
               rd_ptr <= rd_ptr + PW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_sd_sector_buffer_ctrl.sv
// Directed bench for sd_sector_buffer_ctrl with a behavioural 1024x8 registered-read BRAM.
module tb_sd_sector_buffer_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid, wr_sof, rd_req;
   logic [7:0]  wr_data;
   logic        rd_gnt, rd_valid, rd_last, sector_ready, wr_overflow, wr_abort;
   logic [7:0]  rd_data, bram_data_in, bram_data_out;
   logic [9:0]  bram_addr;
   logic        bram_wr_en;
   logic [7:0]  mem [1024];

   int n_tests = 0;
   int n_fail  = 0;
   int wcnt;

   always #5 clk = ~clk;

   sd_sector_buffer_ctrl dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_sof(wr_sof), .wr_data(wr_data),
      .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
      .rd_last(rd_last), .sector_ready(sector_ready),
      .wr_overflow(wr_overflow), .wr_abort(wr_abort),
      .bram_addr(bram_addr), .bram_wr_en(bram_wr_en),
      .bram_data_in(bram_data_in), .bram_data_out(bram_data_out)
   );

   always @(posedge clk) begin
      if (bram_wr_en) mem[bram_addr] <= bram_data_in;
      bram_data_out <= mem[bram_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // All stimulus is applied 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bytes(input bit counting, input logic [7:0] fill, input int n,
                             output int wc);
      wc = 0;
      for (int i = 0; i < n; i++) begin
         wr_valid = 1'b1;
         wr_sof   = (i == 0);
         wr_data  = counting ? 8'(i) : fill;
         #1;
         if (bram_wr_en === 1'b1) wc++;
         tick();
      end
      wr_valid = 1'b0;
      wr_sof   = 1'b0;
   endtask

   task automatic drain(input string tag, input bit counting, input logic [7:0] fill);
      int granted = 0;
      int got = 0;
      int bad = 0;
      int lat_bad = 0;
      int last_cnt = 0;
      int last_pos = -1;
      int cyc = 0;
      bit prev_gnt = 1'b0;
      logic [7:0] exp;
      while (got < 512 && cyc < 4000) begin
         if (rd_valid !== prev_gnt) lat_bad++;
         if (rd_valid === 1'b1) begin
            exp = counting ? 8'(got) : fill;
            if (rd_data !== exp) bad++;
            if (rd_last === 1'b1) begin
               last_cnt++;
               last_pos = got;
            end
            got++;
         end else if (rd_last !== 1'b0) begin
            last_cnt++;
         end
         rd_req = (granted < 512);
         #1;
         prev_gnt = (rd_gnt === 1'b1);
         if (prev_gnt) granted++;
         tick();
         cyc++;
      end
      rd_req = 1'b0;
      check({tag, "_count"}, got, 512);
      check({tag, "_data_err"}, bad, 0);
      check({tag, "_latency_err"}, lat_bad, 0);
      check({tag, "_last_cnt"}, last_cnt, 1);
      check({tag, "_last_pos"}, last_pos, 511);
   endtask

   initial begin
      rst = 1'b1; wr_valid = 1'b0; wr_sof = 1'b0; wr_data = '0; rd_req = 1'b0;
      repeat (3) tick();
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_last", rd_last, 0);
      check("rst_sector_ready", sector_ready, 0);
      check("rst_overflow", wr_overflow, 0);
      check("rst_abort", wr_abort, 0);
      check("rst_wr_en", bram_wr_en, 0);
      check("rst_addr", bram_addr, 0);
      rst = 1'b0;
      tick();

      // Nothing full: request is refused.
      rd_req = 1'b1; #1;
      check("empty_gnt", rd_gnt, 0);
      rd_req = 1'b0;
      tick();

      // Single sector into bank 0.
      send_bytes(1'b1, 8'h00, 512, wcnt);
      check("single_wr_cnt", wcnt, 512);
      tick();
      check("single_ready", sector_ready, 1);
      drain("single", 1'b1, 8'h00);
      tick();
      check("single_ready_after", sector_ready, 0);

      // Ping-pong: A into bank 1, B into bank 0, third sector dropped.
      send_bytes(1'b0, 8'hA5, 512, wcnt);
      send_bytes(1'b0, 8'h5A, 512, wcnt);
      tick();
      check("pp_ready", sector_ready, 1);
      check("pp_no_ovf_yet", wr_overflow, 0);
      send_bytes(1'b0, 8'h77, 512, wcnt);
      tick();
      check("ovf_wr_cnt", wcnt, 0);
      check("ovf_flag", wr_overflow, 1);
      drain("pp_a", 1'b0, 8'hA5);
      send_bytes(1'b0, 8'h11, 512, wcnt);
      check("ovf_retry_wr_cnt", wcnt, 512);
      drain("pp_b", 1'b0, 8'h5A);
      drain("pp_c", 1'b0, 8'h11);
      tick();
      check("pp_ready_after", sector_ready, 0);

      // Abort: 100 bytes, then a new sof and a full 0x3C sector.
      send_bytes(1'b1, 8'h00, 100, wcnt);
      check("abort_not_yet", wr_abort, 0);
      send_bytes(1'b0, 8'h3C, 512, wcnt);
      tick();
      check("abort_flag", wr_abort, 1);
      drain("abort", 1'b0, 8'h3C);

      // Collision: bank 1 full of 0xC3, writer starts bank 0 while host reads.
      send_bytes(1'b0, 8'hC3, 512, wcnt);
      tick();
      wr_valid = 1'b1; wr_sof = 1'b1; wr_data = 8'h42; rd_req = 1'b1; #1;
      check("coll_gnt", rd_gnt, 0);
      check("coll_wr_en", bram_wr_en, 1);
      check("coll_addr_wr", bram_addr, 10'd0);
      tick();
      wr_valid = 1'b0; wr_sof = 1'b0; #1;
      check("coll_gnt_next", rd_gnt, 1);
      check("coll_addr_rd", bram_addr, 10'd512);
      tick();
      rd_req = 1'b0;
      check("coll_rd_valid", rd_valid, 1);
      check("coll_rd_data", rd_data, 8'hC3);
      tick();

      // Reset at byte 300 of a fill.
      send_bytes(1'b1, 8'h00, 300, wcnt);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("mid_rst_ready", sector_ready, 0);
      check("mid_rst_ovf", wr_overflow, 0);
      check("mid_rst_abort", wr_abort, 0);
      wr_valid = 1'b1; wr_sof = 1'b0; wr_data = 8'hEE; #1;
      check("mid_rst_wait_ignores", bram_wr_en, 0);
      tick();
      wr_valid = 1'b0;
      send_bytes(1'b0, 8'h99, 511, wcnt);
      tick();
      check("mid_rst_partial_ready", sector_ready, 0);
      wr_valid = 1'b1; wr_sof = 1'b0; wr_data = 8'h99;
      tick();
      wr_valid = 1'b0;
      tick();
      check("mid_rst_full_ready", sector_ready, 1);
      drain("post_rst", 1'b0, 8'h99);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sd_sector_buffer_ctrl.md
Name: sd_sector_buffer_ctrl

Overview:
- Arbitration controller for the 1024x8 single-port sector BRAM.
- Splits the BRAM into two 512-byte banks (ping-pong): bank 0 at addr 0-511, bank 1 at addr 512-1023.
- The SPI receive path writes sector bytes into one bank while the host side drains the other.
- Sits between the SD SPI byte receiver, the BRAM and the host read logic. It owns the BRAM addr, wr_en and data_in pins.

Parameters:
- ADDR_W, 10, BRAM address width. The bank-select bit is bit ADDR_W-1.
- DATA_W, 8, byte width.
- SECTOR_BYTES, 512, bytes per bank. Must equal 2**(ADDR_W-1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  one-cycle strobe: SPI receiver has a byte.
- wr_sof  in  1  qualifies wr_valid: this byte is the first data byte of a sector (after the 0xFE token).
- wr_data  in  DATA_W  SPI byte.
- rd_req  in  1  host requests the next byte (level; one byte per granted cycle).
- rd_gnt  out  1  combinational: the request is accepted this cycle.
- rd_valid  out  1  registered: rd_data is valid this cycle.
- rd_data  out  DATA_W  byte read (bram_data_out passthrough).
- rd_last  out  1  registered, coincident with rd_valid on byte 511 of the bank.
- sector_ready  out  1  at least one bank is full.
- wr_overflow  out  1  sticky: a sector was dropped because no bank was free.
- wr_abort  out  1  sticky: wr_sof arrived mid-sector.
- bram_addr  out  ADDR_W  combinational BRAM address.
- bram_wr_en  out  1  combinational BRAM write enable.
- bram_data_in  out  DATA_W  combinational BRAM write data (= wr_data).
- bram_data_out  in  DATA_W  BRAM registered read data.

Behaviour:
- Reset values: all outputs 0; full[1:0]=0; wr_bank=0, rd_bank=0; wr_ptr=0, rd_ptr=0; write FSM in WR_WAIT; both sticky flags cleared.
- BRAM contents are not cleared by reset.
- Write FSM states: WR_WAIT, WR_FILL, WR_DROP.
- WR_WAIT:
  - wr_valid without wr_sof: ignored.
  - wr_valid & wr_sof with full[wr_bank]=0: write byte to {wr_bank, 0}, set wr_ptr=1, go to WR_FILL.
  - wr_valid & wr_sof with full[wr_bank]=1: set wr_overflow, set drop_cnt=1, go to WR_DROP.
- WR_FILL:
  - wr_valid & ~wr_sof: write to {wr_bank, wr_ptr}, then wr_ptr++.
  - When the byte at ptr 511 is written: set full[wr_bank], toggle wr_bank, wr_ptr=0, go to WR_WAIT.
  - wr_valid & wr_sof: set wr_abort, restart the sector (write at ptr 0, wr_ptr=1), stay in WR_FILL.
- WR_DROP:
  - Count wr_valid strobes without writing the BRAM.
  - After the 512th byte, return to WR_WAIT.
  - wr_sof in WR_DROP restarts as if in WR_WAIT.
- Write strobes are never stalled. A write always wins the BRAM in its cycle: bram_wr_en=1, bram_addr={wr_bank, wr_ptr}.
- Read grant: rd_gnt = rd_req & full[rd_bank] & ~(write accepted this cycle).
  - On grant: bram_addr={rd_bank, rd_ptr}, then rd_ptr++.
- Read latency: rd_valid is asserted exactly 1 cycle after rd_gnt, with rd_data = bram_data_out.
- Read bank release: a grant at rd_ptr=511 clears full[rd_bank] at the next edge, toggles rd_bank and sets rd_ptr=0. rd_last is asserted with that byte's rd_valid.
- Simultaneous events:
  - The set of full[x] by the writer and the clear of full[y] by the reader in the same cycle are both applied.
  - The writer never targets a full bank, so x≠y is guaranteed.
- Idle bus: when neither a write nor a grant occurs, bram_addr holds {rd_bank, rd_ptr} and bram_wr_en=0.
- sector_ready = full[0] | full[1], registered from the full flags.
- Reset mid-operation discards partial and full sectors; the host must re-issue the read command.

Decomposition:
- Shared package sd_buf_pkg holds:
  - write FSM state enum (WR_WAIT, WR_FILL, WR_DROP);
  - SECTOR_BYTES;
  - bank-index and pointer widths.
- No sub-module. The BRAM stays a separate instance wired by the parent.

Test Plan:
- Single sector: sof + 512 bytes 0x00..0xFF repeating -> bank0 full, sector_ready=1. Host drains 512 bytes with rd_valid 1 cycle after each rd_gnt, data matches, rd_last on byte 511, sector_ready=0.
- Collision: wr_valid and rd_req in the same cycle -> rd_gnt=0, bram_wr_en=1; the read is granted the next cycle with the correct data.
- Ping-pong: write sector A (0xA5 fill) then sector B (0x5A) without reading -> full=2'b11. Reads return 512x0xA5 then 512x0x5A.
- Overflow: with both banks full, a third sof + 512 bytes -> wr_overflow=1, no bram_wr_en, FSM back to WR_WAIT. The next sof after one bank drains is accepted.
- Abort: sof, 100 bytes, sof, 512 bytes 0x3C -> wr_abort=1; bank0 reads 512x0x3C.
- Reset at byte 300 of a fill -> all flags 0, FSM WR_WAIT, sector_ready stays 0 until a full new sector is written.
